// File: rtl/toggle_pulse_decoder.sv
// Destination end of a toggle-encoded event crossing: synchronizes the toggle line, turns each
// level change into a one-cycle pulse, counts events and holds them in a valid/ack handshake.
module toggle_pulse_decoder #(
    parameter int unsigned SYNC_STAGES = 2,  // legal range 2..4
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             evt_ack,
    input  logic             ovr_clr,
    output logic             pulse,
    output logic             evt_valid,
    output logic             overrun,
    output logic [CNT_W-1:0] evt_count
);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StPend = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   t_sync;
    logic                   t_prev;
    logic                   det;
    state_e                 state;
    state_e                 state_next;
    logic                   overrun_next;

    assign t_sync = sync_ff[SYNC_STAGES-1];
    assign det    = t_sync ^ t_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff   <= '0;
            t_prev    <= 1'b0;
            pulse     <= 1'b0;
            evt_count <= '0;
            state     <= StIdle;
            overrun   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], t_in};
            t_prev  <= t_sync;
            pulse   <= det;
            if (det) begin
                evt_count <= evt_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            state   <= state_next;
            overrun <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        overrun_next = overrun;
        if (ovr_clr) begin
            overrun_next = 1'b0;
        end
        unique case (state)
            StIdle: begin
                if (det) begin
                    state_next = StPend;
                end
            end
            StPend: begin
                // An ack coinciding with a new event hands the slot to the new event.
                if (evt_ack && !det) begin
                    state_next = StIdle;
                end else if (det && !evt_ack) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    assign evt_valid = (state == StPend);

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Directed bench for toggle_pulse_decoder: default instance plus a 4-bit counter instance
// sharing the same stimulus for the wrap case.
module tb_toggle_pulse_decoder;

    logic       clk;
    logic       reset;
    logic       t_in;
    logic       evt_ack;
    logic       ovr_clr;
    logic       pulse;
    logic       evt_valid;
    logic       overrun;
    logic [7:0] evt_count;
    logic       pulse4;
    logic       evt_valid4;
    logic       overrun4;
    logic [3:0] evt_count4;

    int n_checks = 0;
    int n_errors = 0;

    toggle_pulse_decoder #(
        .SYNC_STAGES(2),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .t_in     (t_in),
        .evt_ack  (evt_ack),
        .ovr_clr  (ovr_clr),
        .pulse    (pulse),
        .evt_valid(evt_valid),
        .overrun  (overrun),
        .evt_count(evt_count)
    );

    toggle_pulse_decoder #(
        .SYNC_STAGES(2),
        .CNT_W      (4)
    ) dut4 (
        .clk      (clk),
        .reset    (reset),
        .t_in     (t_in),
        .evt_ack  (evt_ack),
        .ovr_clr  (ovr_clr),
        .pulse    (pulse4),
        .evt_valid(evt_valid4),
        .overrun  (overrun4),
        .evt_count(evt_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        t_in    = 1'b0;
        evt_ack = 1'b0;
        ovr_clr = 1'b0;
        reset   = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    // One toggle: pulse appears after the third edge and lasts one cycle.
    task automatic send_evt(input string tag);
        t_in = ~t_in;
        tick(2);
        check_eq({tag, " pulse early"}, pulse, 0);
        tick(1);
        check_eq({tag, " pulse"}, pulse, 1);
        tick(1);
        check_eq({tag, " pulse end"}, pulse, 0);
        tick(6);
    endtask

    logic seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int npulse;
        int novr;
        bit ack_pending;

        // Reset and first toggle.
        reset   = 1'b0;
        t_in    = 1'b0;
        evt_ack = 1'b0;
        ovr_clr = 1'b0;
        #6;
        check_eq("rst pulse", pulse, 0);
        check_eq("rst valid", evt_valid, 0);
        check_eq("rst overrun", overrun, 0);
        check_eq("rst count", evt_count, 0);
        #6;
        reset = 1'b1;
        tick(1);
        npulse = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            npulse += int'(pulse) + int'(evt_valid) + int'(overrun) + int'(evt_count);
        end
        check_eq("idle outputs", npulse, 0);
        send_evt("first");
        check_eq("first count", evt_count, 1);
        check_eq("first valid", evt_valid, 1);

        // Sequence 1,0,0,1,0 with prompt ack.
        do_reset();
        npulse      = 0;
        novr        = 0;
        ack_pending = 1'b0;
        for (int s = 0; s < 5; s++) begin
            t_in = seq[s];
            for (int c = 0; c < 10; c++) begin
                tick(1);
                if (ack_pending) begin
                    check_eq("seq valid drop", evt_valid, 0);
                    ack_pending = 1'b0;
                    evt_ack     = 1'b0;
                end
                if (overrun) novr++;
                if (pulse) begin
                    npulse++;
                    evt_ack     = 1'b1;
                    ack_pending = 1'b1;
                end
            end
        end
        check_eq("seq pulses", npulse, 4);
        check_eq("seq count", evt_count, 4);
        check_eq("seq overrun", novr, 0);

        // Three toggles, ack low.
        do_reset();
        send_evt("noack1");
        check_eq("noack1 valid", evt_valid, 1);
        check_eq("noack1 overrun", overrun, 0);
        send_evt("noack2");
        check_eq("noack2 overrun", overrun, 1);
        send_evt("noack3");
        check_eq("noack3 count", evt_count, 3);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check_eq("ovr_clr overrun", overrun, 0);
        check_eq("ovr_clr valid", evt_valid, 1);
        // Set and clear in the same cycle: set wins.
        ovr_clr = 1'b1;
        t_in    = ~t_in;
        tick(3);
        ovr_clr = 1'b0;
        check_eq("set wins pulse", pulse, 1);
        check_eq("set wins overrun", overrun, 1);
        tick(1);
        check_eq("set wins hold", overrun, 1);
        check_eq("set wins count", evt_count, 4);

        // Mid-operation async reset while valid and overrun are high.
        #2;
        reset = 1'b0;
        #1;
        check_eq("async rst pulse", pulse, 0);
        check_eq("async rst valid", evt_valid, 0);
        check_eq("async rst overrun", overrun, 0);
        check_eq("async rst count", evt_count, 0);
        t_in = 1'b1;
        tick(2);
        #2;
        reset  = 1'b1;
        npulse = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (pulse) npulse++;
        end
        check_eq("rst high pulses", npulse, 1);
        check_eq("rst high count", evt_count, 1);
        check_eq("rst high valid", evt_valid, 1);

        // Ack in the same cycle as the next det.
        do_reset();
        send_evt("coinc first");
        t_in = ~t_in;
        tick(2);
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
        check_eq("coinc pulse", pulse, 1);
        check_eq("coinc valid", evt_valid, 1);
        check_eq("coinc overrun", overrun, 0);
        tick(3);
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
        check_eq("coinc final ack", evt_valid, 0);
        check_eq("coinc count", evt_count, 2);

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            send_evt("wrap");
            if (i == 15) check_eq("wrap 15", evt_count4, 15);
            if (i == 16) check_eq("wrap 16", evt_count4, 0);
            if (i == 17) check_eq("wrap 17", evt_count4, 1);
        end
        check_eq("wide count 17", evt_count, 17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
